// File: rtl/pls_cnt_pkg.sv
// Shared constants and the load clamp rule
// for the modulo pulse counters.
package pls_cnt_pkg;

  localparam int MOD_SEC  = 60;
  localparam int MOD_MIN  = 60;
  localparam int MOD_HOUR = 24;

  // Presets beyond the top count saturate to MOD-1.
  function automatic int unsigned clamp_ld(
    input int unsigned v,
    input int unsigned m
  );
    return (v > m - 1) ? m - 1 : v;
  endfunction

endpackage

// File: rtl/pls_cnt_mod_edge_sync.sv
// Two-flop synchronizer with a single-cycle
// rise or fall pulse and a synchronous flush.
module edge_sync #(
  parameter bit FALL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic d,
  output logic pulse
);

  logic s0_q, s0_d;
  logic s1_q, s1_d;

  always_comb begin
    s0_d = flush ? 1'b0 : d;
    s1_d = flush ? 1'b0 : s0_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end

  assign pulse = FALL ? (s1_q & ~s0_q)
                      : (s0_q & ~s1_q);

endmodule

// File: rtl/pls_cnt_mod.sv
// Modulo up/down pulse counter with clear, load,
// half-scale flag and a one-cycle wrap pulse.
module pls_cnt_mod
  import pls_cnt_pkg::*;
#(
  parameter int MOD  = 60,
  parameter int HALF = MOD / 2,
  parameter int W    = $clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         plsi,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         dn,
  input  logic         en,
  output logic [W-1:0] qout,
  output logic         plso,
  output logic         cout
);

  localparam logic [W-1:0] MAX    = W'(MOD - 1);
  localparam logic [W:0]   HALF_W = (W + 1)'(HALF);

  logic clr_ev, ld_ev, cnt_ev, flush;
  logic [W-1:0] ldc;

  logic [W-1:0] q_q, q_d;
  logic plso_q, plso_d;
  logic cout_q, cout_d;
  logic upd;

  edge_sync #(.FALL(1'b0)) u_clr (
    .clk(clk), .rst_n(rst), .flush(1'b0),
    .d(clr), .pulse(clr_ev)
  );

  edge_sync #(.FALL(1'b0)) u_ld (
    .clk(clk), .rst_n(rst), .flush(1'b0),
    .d(ld), .pulse(ld_ev)
  );

  // Pending plsi edges die on clear/load.
  edge_sync #(.FALL(1'b1)) u_pls (
    .clk(clk), .rst_n(rst), .flush(flush),
    .d(plsi), .pulse(cnt_ev)
  );

  assign flush = clr_ev | ld_ev;
  assign ldc   = W'(clamp_ld(32'(ld_val), MOD));

  always_comb begin
    q_d    = q_q;
    plso_d = plso_q;
    cout_d = 1'b0;
    upd    = 1'b0;
    if (clr_ev) begin
      q_d    = '0;
      plso_d = 1'b0;
    end else if (ld_ev) begin
      q_d = ldc;
      upd = 1'b1;
    end else if (cnt_ev && en) begin
      upd = 1'b1;
      if (!dn) begin
        if (q_q >= MAX) begin
          q_d    = '0;
          cout_d = 1'b1;
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if (q_q == '0) begin
          q_d    = MAX;
          cout_d = 1'b1;
        end else if (q_q > MAX) begin
          q_d = MAX;
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
    if (upd) plso_d = ({1'b0, q_d} >= HALF_W);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= '0;
      plso_q <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      plso_q <= plso_d;
      cout_q <= cout_d;
    end
  end

  assign qout = q_q;
  assign plso = plso_q;
  assign cout = cout_q;

endmodule
